// File: rtl/result_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_tx_framer_pkg
// Description : Shared types and constants for the result UART framer.
// Revision    : 1.0 - initial release
// ============================================================================
package result_tx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SNAP      = 3'd1,
        SEND      = 3'd2,
        BYTE_WAIT = 3'd3,
        DONE      = 3'd4,
        HOLD      = 3'd5
    } state_t;

    localparam logic [7:0] HEADER      = 8'hA5;
    localparam int         FRAME_BYTES = 34;

    // Payload byte p (0..31): element p/2 in row-major order, MSB byte first.
    function automatic logic [7:0] payload_byte(input logic [0:3][0:3][15:0] m,
                                                input logic [4:0]            p);
        logic [15:0] w;
        w = m[p[4:3]][p[2:1]];
        return p[0] ? w[7:0] : w[15:8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_tx_framer_uart.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer; owns the baud and bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       tx,
    output logic       ready,
    output logic       done
);
    localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    logic          busy_q,  busy_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [3:0]    bit_q,   bit_d;
    logic [8:0]    shreg_q, shreg_d;
    logic          tx_q,    tx_d;
    logic          done_q,  done_d;

    always_comb begin
        busy_d  = busy_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (!busy_q) begin
            if (valid) begin
                // Start bit goes out immediately; stop bit rides above the data.
                busy_d  = 1'b1;
                shreg_d = {1'b1, data};
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
            end
        end else if (baud_q == BAUD_MAX) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                tx_d   = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                tx_d    = shreg_q[0];
                shreg_d = {1'b1, shreg_q[8:1]};
            end
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '1;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = !busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: rtl/result_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : result_tx_framer
// Description : Snapshots the 4x4 result matrix and sends it as a UART frame.
// Revision    : 1.0 - initial release
// ============================================================================
module result_tx_framer #(
    parameter int         CLK_FREQ = 125_000_000,
    parameter int         BAUD     = 115200,
    parameter logic [7:0] HEADER   = result_tx_framer_pkg::HEADER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [0:3][0:3][15:0] C,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    import result_tx_framer_pkg::*;

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [5:0] LAST_IDX     = 6'(FRAME_BYTES - 1);

    state_t                state_q, state_d;
    logic [5:0]            idx_q,   idx_d;
    logic [7:0]            csum_q,  csum_d;
    logic [0:3][0:3][15:0] frame_q, frame_d;

    logic [7:0] tx_byte;
    logic [4:0] pidx;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_done;

    always_comb begin
        pidx = 5'(idx_q - 6'd1);
        if (idx_q == 6'd0)
            tx_byte = HEADER;
        else if (idx_q == LAST_IDX)
            tx_byte = csum_q;
        else
            tx_byte = payload_byte(frame_q, pidx);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        frame_d   = frame_q;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = SNAP;
            SNAP: begin
                busy    = 1'b1;
                frame_d = C;
                idx_d   = '0;
                csum_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                busy = 1'b1;
                if (ser_ready) begin
                    ser_valid = 1'b1;
                    // Checksum covers payload only, accumulated as bytes leave.
                    if (idx_q != 6'd0 && idx_q != LAST_IDX)
                        csum_d = csum_q ^ tx_byte;
                    state_d = BYTE_WAIT;
                end
            end
            BYTE_WAIT: begin
                busy = 1'b1;
                if (ser_done) begin
                    idx_d   = idx_q + 6'd1;
                    state_d = (idx_d == 6'(FRAME_BYTES)) ? DONE : SEND;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = HOLD;
            end
            HOLD:    if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .data  (tx_byte),
        .valid (ser_valid),
        .tx    (tx),
        .ready (ser_ready),
        .done  (ser_done)
    );

endmodule
`default_nettype wire
